// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package cmp_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // One-hot result encodings, ordered {G, E, L}
    localparam logic [2:0] RES_G    = 3'b100;
    localparam logic [2:0] RES_E    = 3'b010;
    localparam logic [2:0] RES_L    = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/msb_step_cell.sv
// One MSB-first compare step: decides on a differing bit pair, or on
// equality once the final (LSB) position is reached.
module msb_step_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic last,
    output logic gt,
    output logic lt,
    output logic eq_final,
    output logic decide
);

    // Pure combinational decision for the current bit position
    always_comb begin
        gt       = a_bit & ~b_bit;
        lt       = ~a_bit & b_bit;
        eq_final = ~(a_bit ^ b_bit) & last;
        decide   = gt | lt | eq_final;
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator. Scans latched operands MSB-first,
// one bit per clock, and stops at the first differing bit.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             E,
    output logic             L
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       res_q, res_d;
    logic             load, dec;

    logic gt, lt, eq_final, decide;

    msb_step_cell u_step (
        .a_bit    (a_q[idx_q]),
        .b_bit    (b_q[idx_q]),
        .last     (idx_q == '0),
        .gt       (gt),
        .lt       (lt),
        .eq_final (eq_final),
        .decide   (decide)
    );

    // Next-state, result update and datapath enables
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    res_d   = RES_NONE;
                    state_d = SCAN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (gt) begin
                    res_d = RES_G;
                end else if (lt) begin
                    res_d = RES_L;
                end else if (eq_final) begin
                    res_d = RES_E;
                end
                if (decide) begin
                    state_d = DONE;
                end else begin
                    // eq_final covers idx==0, so this never wraps
                    dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, index and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (load) begin
                a_q   <= A;
                b_q   <= B;
                idx_q <= IDX_W'(WIDTH - 1);
            end else if (dec) begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    // Registered outputs decoded from state and result flags
    always_comb begin
        busy      = (state_q == SCAN);
        done      = (state_q == DONE);
        {G, E, L} = res_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: a latency/result model compared every cycle against a
// WIDTH=8 and a WIDTH=1 instance, plus directed literal expectations.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ain [2];
    logic [7:0] bin [2];
    logic       stv [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       g_v [2];
    logic       e_v [2];
    logic       l_v [2];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (stv[0]),
        .A     (ain[0]),
        .B     (bin[0]),
        .busy  (busy_v[0]),
        .done  (done_v[0]),
        .G     (g_v[0]),
        .E     (e_v[0]),
        .L     (l_v[0])
    );

    serial_magnitude_comparator #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (stv[1]),
        .A     (ain[1][0:0]),
        .B     (bin[1][0:0]),
        .busy  (busy_v[1]),
        .done  (done_v[1]),
        .G     (g_v[1]),
        .E     (e_v[1]),
        .L     (l_v[1])
    );

    function automatic int width_of(int d);
        return (d == 0) ? 8 : 1;
    endfunction

    // Edges from acceptance to decision: W - p for first differing bit p
    function automatic int ref_lat(logic [7:0] a, logic [7:0] b, int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return w - i;
        end
        return w;
    endfunction

    function automatic logic [2:0] ref_res(logic [7:0] a, logic [7:0] b, int w);
        logic [7:0] am, bm;
        am = (w == 8) ? a : {7'b0, a[0]};
        bm = (w == 8) ? b : {7'b0, b[0]};
        if (am > bm) return 3'b100;
        if (am == bm) return 3'b010;
        return 3'b001;
    endfunction

    // Behavioural model: countdown of the arithmetic latency, result on expiry
    logic       m_busy [2];
    logic       m_done [2];
    logic [2:0] m_res  [2];
    logic [2:0] m_pend [2];
    int         m_rem  [2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_res[d]  <= 3'b000;
                m_rem[d]  <= 0;
            end else if (m_busy[d]) begin
                m_rem[d] <= m_rem[d] - 1;
                if (m_rem[d] == 1) begin
                    m_busy[d] <= 1'b0;
                    m_done[d] <= 1'b1;
                    m_res[d]  <= m_pend[d];
                end
            end else begin
                m_done[d] <= 1'b0;
                if (stv[d]) begin
                    m_busy[d] <= 1'b1;
                    m_res[d]  <= 3'b000;
                    m_rem[d]  <= ref_lat(ain[d], bin[d], width_of(d));
                    m_pend[d] <= ref_res(ain[d], bin[d], width_of(d));
                end
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison of {busy, done, G, E, L} against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("model_w%0d_cyc%0d", width_of(d), cyc),
                64'({busy_v[d], done_v[d], g_v[d], e_v[d], l_v[d]}),
                64'({m_busy[d], m_done[d], m_res[d]}));
        end
    end

    task automatic go(int d, logic [7:0] a, logic [7:0] b, bit hold);
        @(negedge clk);
        ain[d] = a;
        bin[d] = b;
        stv[d] = 1'b1;
        @(negedge clk);
        if (!hold) stv[d] = 1'b0;
        t0 = cyc;
    endtask

    task automatic expect_done(int d, int lat, int bexp, logic [2:0] f, string nm);
        int bc = 0;
        while (done_v[d] !== 1'b1 && (cyc - t0) <= 40) begin
            if (busy_v[d] === 1'b1) bc++;
            @(negedge clk);
        end
        chk({nm, "_done"}, 64'(done_v[d]), 64'(1));
        chk({nm, "_latency"}, 64'(cyc - t0), 64'(lat));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(bexp));
        chk({nm, "_flags"}, 64'({g_v[d], e_v[d], l_v[d]}), 64'(f));
    endtask

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            ain[d] = '0;
            bin[d] = '0;
            stv[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", 64'({busy_v[0], done_v[0], g_v[0], e_v[0], l_v[0]}), 64'(0));

        // Reset mid-operation
        go(0, 8'h80, 8'h80, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", 64'({busy_v[0], done_v[0], g_v[0], e_v[0], l_v[0]}), 64'(0));
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));

        go(0, 8'hA5, 8'h25, 1'b0);
        expect_done(0, 1, 1, 3'b100, "msb_exit");

        go(0, 8'h3C, 8'h3C, 1'b0);
        expect_done(0, 8, 8, 3'b010, "equal");

        go(0, 8'h10, 8'h11, 1'b0);
        expect_done(0, 8, 8, 3'b001, "lsb_exit");

        // Second start sampled at T2 must be ignored
        go(0, 8'hF0, 8'hF1, 1'b0);
        @(negedge clk);
        stv[0] = 1'b1;
        ain[0] = 8'h00;
        bin[0] = 8'h00;
        @(negedge clk);
        stv[0] = 1'b0;
        expect_done(0, 8, 6, 3'b001, "start_ignored");

        // Back-to-back with start held through DONE
        go(0, 8'h01, 8'h00, 1'b1);
        ain[0] = 8'h00;
        bin[0] = 8'h01;
        expect_done(0, 8, 8, 3'b100, "b2b_first");
        @(negedge clk);
        stv[0] = 1'b0;
        t0     = cyc;
        chk("b2b_accept", 64'({busy_v[0], g_v[0], e_v[0], l_v[0]}), 64'(4'b1000));
        expect_done(0, 8, 8, 3'b001, "b2b_second");

        // WIDTH=1: all four input pairs
        go(1, 8'h00, 8'h00, 1'b0);
        expect_done(1, 1, 1, 3'b010, "w1_00");
        go(1, 8'h00, 8'h01, 1'b0);
        expect_done(1, 1, 1, 3'b001, "w1_01");
        go(1, 8'h01, 8'h00, 1'b0);
        expect_done(1, 1, 1, 3'b100, "w1_10");
        go(1, 8'h01, 8'h01, 1'b0);
        expect_done(1, 1, 1, 3'b010, "w1_11");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
